// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through reads.
// Includes an occupancy count, almost-full/almost-empty levels, sticky error flags and flush.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          din,
    input  logic                       win_en,
    input  logic                       rout_en,
    input  logic                       flush,
    input  logic                       clr_err,
    output logic [DATA_W-1:0]          dout,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_LVL   = (ADDR_W+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;

    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign almost_full  = (count_q >= AF_LVL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Flush wins over both requests, so nothing moves on a flush edge.
    assign wr_acc = win_en  && !full  && !flush;
    assign rd_acc = rout_en && !empty && !flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q  && !clr_err;
        underflow_d = underflow_q && !clr_err;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
            else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
            // A new error on the same edge as clr_err keeps the flag set.
            if (win_en  && full)  overflow_d  = 1'b1;
            if (rout_en && empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = empty ? '0 : mem[rd_ptr_q];
        end else begin : g_std
            logic [DATA_W-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (flush)       dout_d = '0;
                else if (rd_acc) dout_d = mem[rd_ptr_q];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dout_q <= '0;
                else        dout_q <= dout_d;
            end

            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: standard-read FIFO (DEPTH=8, AF=6, AE=2) and an FWFT twin sharing stimulus.
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       win_en, rout_en, flush, clr_err;

    logic [7:0] dout0, dout1;
    logic       empty0, full0, ae0, af0, ov0, un0;
    logic       empty1, full1, ae1, af1, ov1, un1;
    logic [3:0] count0, count1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .win_en(win_en), .rout_en(rout_en),
        .flush(flush), .clr_err(clr_err), .dout(dout0), .empty(empty0), .full(full0),
        .almost_empty(ae0), .almost_full(af0), .count(count0), .overflow(ov0), .underflow(un0));

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .win_en(win_en), .rout_en(rout_en),
        .flush(flush), .clr_err(clr_err), .dout(dout1), .empty(empty1), .full(full1),
        .almost_empty(ae1), .almost_full(af1), .count(count1), .overflow(ov1), .underflow(un1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given requests, then sample 1ns after the edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        win_en  = w;
        rout_en = r;
        din     = d;
        @(posedge clk);
        #1;
        win_en  = 1'b0;
        rout_en = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
    endtask

    logic [7:0] q[$];
    logic [7:0] expv;
    logic       w, r, wa, ra;
    int         nw, guard;

    initial begin
        rst_n = 1'b0; din = '0; win_en = 1'b0; rout_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        #12;
        chk("rst_count", 32'(count0), 0);
        chk("rst_empty", 32'(empty0), 1);
        chk("rst_full",  32'(full0),  0);
        chk("rst_ae",    32'(ae0),    1);
        chk("rst_af",    32'(af0),    0);
        chk("rst_dout",  32'(dout0),  0);
        chk("rst_ov",    32'(ov0),    0);
        chk("rst_un",    32'(un0),    0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write then read, registered dout.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'h11 + i));
        chk("s1_count4", 32'(count0), 4);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("s1_dout", 32'(dout0), 32'(8'h11 + i));
        end
        chk("s1_empty", 32'(empty0), 1);
        cyc(1'b0, 1'b0, 8'h00);
        chk("s1_dout_hold", 32'(dout0), 32'h14);

        // Fill, overflow attempt, drain.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
        chk("s2_full", 32'(full0), 1);
        chk("s2_count8", 32'(count0), 8);
        cyc(1'b1, 1'b0, 8'hAA);
        chk("s2_ov", 32'(ov0), 1);
        chk("s2_count_stay", 32'(count0), 8);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("s2_dout", 32'(dout0), 32'(8'h20 + i));
        end
        chk("s2_empty", 32'(empty0), 1);
        clr_err = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        chk("s2_ov_clr", 32'(ov0), 0);

        // Simultaneous read/write at count=3, then at empty.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 8'(8'h40 + i));
            chk("s3_count3", 32'(count0), 3);
            chk("s3_dout", 32'(dout0), (i < 3) ? 32'(8'h30 + i) : 32'(8'h40 + i - 3));
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("s3_drain", 32'(dout0), 32'(8'h42 + i));
        end
        cyc(1'b1, 1'b1, 8'h50);
        chk("s3_un", 32'(un0), 1);
        chk("s3_count1", 32'(count0), 1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("s3_dout50", 32'(dout0), 32'h50);
        clr_err = 1'b1;
        cyc(1'b0, 1'b1, 8'h00);
        chk("s3_set_wins", 32'(un0), 1);
        clr_err = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        chk("s3_un_clr", 32'(un0), 0);

        // Random interleave across pointer wrap against a queue model.
        nw = 0; guard = 0;
        while ((nw < 40 || q.size() > 0) && guard < 400) begin
            w  = (nw < 40) && ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            wa = w && (q.size() < 8);
            ra = r && (q.size() > 0);
            cyc(w, r, 8'(8'h60 + nw));
            if (ra) begin
                expv = q.pop_front();
                chk("s4_dout", 32'(dout0), 32'(expv));
            end
            if (wa) begin
                q.push_back(8'(8'h60 + nw));
                nw++;
            end
            chk("s4_count", 32'(count0), 32'(q.size()));
            guard++;
        end
        chk("s4_done", 32'(guard < 400), 1);
        clr_err = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);

        // Almost-full / almost-empty thresholds.
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            chk("s5_ae", 32'(ae0), (i <= 2) ? 1 : 0);
            chk("s5_af", 32'(af0), (i >= 6) ? 1 : 0);
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("s5_empty", 32'(empty0), 1);

        // FWFT instance.
        flush = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        chk("s6_dout_empty", 32'(dout1), 0);
        cyc(1'b1, 1'b0, 8'h5A);
        chk("s6_fwft_dout", 32'(dout1), 32'h5A);
        chk("s6_fwft_empty", 32'(empty1), 0);
        cyc(1'b1, 1'b0, 8'h5B);
        chk("s6_fwft_hold", 32'(dout1), 32'h5A);
        cyc(1'b0, 1'b1, 8'h00);
        chk("s6_fwft_pop", 32'(dout1), 32'h5B);
        flush = 1'b1;
        cyc(1'b1, 1'b1, 8'h77);
        chk("s6_flush_count", 32'(count1), 0);
        chk("s6_flush_empty", 32'(empty1), 1);
        chk("s6_flush_dout", 32'(dout1), 0);
        chk("s6_flush_dout0", 32'(dout0), 0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i));
        chk("s6_burst_count", 32'(count1), 3);
        win_en = 1'b1; din = 8'h90;
        rst_n = 1'b0;
        #2;
        chk("s6_rst_count", 32'(count1), 0);
        chk("s6_rst_empty", 32'(empty1), 1);
        chk("s6_rst_dout",  32'(dout1), 0);
        chk("s6_rst_count0", 32'(count0), 0);
        win_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        chk("s6_after_rst", 32'(empty1), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
